// File: rtl/idex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-bus bit map and the register-update selector.
package idex_hazard_stage_pkg;

    localparam int unsigned CTRL_WIDTH    = 9;
    localparam int unsigned CTRL_MEMREAD  = 0;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_REGWRITE = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_ALUSRC   = 4;
    localparam int unsigned CTRL_BRANCH   = 5;
    localparam int unsigned CTRL_ALUOP_LO = 6;
    localparam int unsigned CTRL_ALUOP_HI = 8;

    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_CAPTURE
    } upd_e;

    // Flush outranks Hold, and Hold outranks the load-use bubble.
    function automatic upd_e select_update(input logic flush, input logic hold,
                                           input logic stall);
        if (flush)      return UPD_FLUSH;
        else if (hold)  return UPD_HOLD;
        else if (stall) return UPD_BUBBLE;
        else            return UPD_CAPTURE;
    endfunction

endpackage

// File: rtl/idex_hazard_stage_if.sv
// Decode-side and forwarding-side signals of the ID/EX stage bundled as one interface.
interface idex_hazard_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 9,
    parameter int unsigned CNT_W  = 16
);
    logic [4:0]        IFID_Rs;
    logic [4:0]        IFID_Rt;
    logic [4:0]        IFID_Rd;
    logic              IFID_UsesRt;
    logic              IFID_Valid;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic [DATA_W-1:0] ID_RsData;
    logic [DATA_W-1:0] ID_RtData;
    logic [DATA_W-1:0] ID_Imm;
    logic              Flush;
    logic              Hold;

    logic [4:0]        IDEX_Rs;
    logic [4:0]        IDEX_Rt;
    logic [4:0]        IDEX_Rd;
    logic [CTRL_W-1:0] IDEX_Ctrl;
    logic [DATA_W-1:0] IDEX_RsData;
    logic [DATA_W-1:0] IDEX_RtData;
    logic [DATA_W-1:0] IDEX_Imm;
    logic              IDEX_Valid;
    logic              LoadUseStall;
    logic              PCWrite;
    logic              IFIDWrite;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output IFID_Rs, IFID_Rt, IFID_Rd, IFID_UsesRt, IFID_Valid,
               ID_Ctrl, ID_RsData, ID_RtData, ID_Imm, Flush, Hold,
        input  IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_Ctrl, IDEX_RsData, IDEX_RtData,
               IDEX_Imm, IDEX_Valid, LoadUseStall, PCWrite, IFIDWrite, StallCount
    );

    modport slave (
        input  IFID_Rs, IFID_Rt, IFID_Rd, IFID_UsesRt, IFID_Valid,
               ID_Ctrl, ID_RsData, ID_RtData, ID_Imm, Flush, Hold,
        output IDEX_Rs, IDEX_Rt, IDEX_Rd, IDEX_Ctrl, IDEX_RsData, IDEX_RtData,
               IDEX_Imm, IDEX_Valid, LoadUseStall, PCWrite, IFIDWrite, StallCount
    );

endinterface

// File: rtl/idex_hazard_detect.sv
// Load-use comparator: a valid load in ID/EX whose target is read by the valid IF/ID instruction.
module idex_hazard_detect (
    input  logic       idex_valid,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic       ifid_valid,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    output logic       load_use_stall
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (idex_rt == ifid_rs);
        rt_match = ifid_uses_rt & (idex_rt == ifid_rt);
        // $zero is hard-wired, so a load into it never creates a dependency.
        load_use_stall = idex_valid & idex_memread & (idex_rt != '0) & ifid_valid
                         & (rs_match | rt_match);
    end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold handling and a saturating stall counter.
module idex_hazard_stage
    import idex_hazard_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = CTRL_WIDTH,
    parameter int unsigned CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    idex_hazard_stage_if.slave bus
);

    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [4:0]        rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              valid_q;
    logic [CNT_W-1:0]  count_q;
    logic              stall;
    upd_e              upd;

    idex_hazard_detect u_detect (
        .idex_valid     (valid_q),
        .idex_memread   (ctrl_q[CTRL_MEMREAD]),
        .idex_rt        (rt_q),
        .ifid_valid     (bus.IFID_Valid),
        .ifid_rs        (bus.IFID_Rs),
        .ifid_rt        (bus.IFID_Rt),
        .ifid_uses_rt   (bus.IFID_UsesRt),
        .load_use_stall (stall)
    );

    always_comb begin
        upd = select_update(bus.Flush, bus.Hold, stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            unique case (upd)
                UPD_FLUSH, UPD_BUBBLE: begin
                    // Zeroing every field clears RegWrite/MemRead and Rd, so forwarding sees no writer.
                    rs_q      <= '0;
                    rt_q      <= '0;
                    rd_q      <= '0;
                    ctrl_q    <= '0;
                    rs_data_q <= '0;
                    rt_data_q <= '0;
                    imm_q     <= '0;
                    valid_q   <= 1'b0;
                end
                UPD_HOLD: begin
                end
                UPD_CAPTURE: begin
                    rs_q      <= bus.IFID_Rs;
                    rt_q      <= bus.IFID_Rt;
                    rd_q      <= bus.IFID_Rd;
                    ctrl_q    <= bus.ID_Ctrl;
                    rs_data_q <= bus.ID_RsData;
                    rt_data_q <= bus.ID_RtData;
                    imm_q     <= bus.ID_Imm;
                    valid_q   <= bus.IFID_Valid;
                end
                default: begin
                end
            endcase
            if ((upd == UPD_BUBBLE) && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.IDEX_Rs      = rs_q;
        bus.IDEX_Rt      = rt_q;
        bus.IDEX_Rd      = rd_q;
        bus.IDEX_Ctrl    = ctrl_q;
        bus.IDEX_RsData  = rs_data_q;
        bus.IDEX_RtData  = rt_data_q;
        bus.IDEX_Imm     = imm_q;
        bus.IDEX_Valid   = valid_q;
        bus.LoadUseStall = stall;
        bus.PCWrite      = ~(stall | bus.Hold);
        bus.IFIDWrite    = ~(stall | bus.Hold);
        bus.StallCount   = count_q;
    end

endmodule
